// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_arb_pkg
// Purpose  : Shared types and helper functions for the ROM read arbiter.
//            MAX_NREQ bounds the requester count. grant_t is a one-hot
//            grant vector sized for MAX_NREQ. onehot_to_idx and rr_pick
//            carry the arbitration arithmetic.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

   localparam int MAX_NREQ = 8;
   localparam int IDXW     = 3;   // enough to index MAX_NREQ requesters

   typedef logic [MAX_NREQ-1:0] grant_t;

   // Binary index of the set bit of a one-hot vector. Returns 0 for all-zero.
   function automatic logic [IDXW-1:0] onehot_to_idx(input grant_t onehot);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int k = 0; k < MAX_NREQ; k++) begin
         if (onehot[k]) idx = idx | IDXW'(k);
      end
      return idx;
   endfunction

   // Round-robin pick. Returns a one-hot grant for the first valid requester
   // found when searching from ptr upward, modulo nreq.
   function automatic grant_t rr_pick(input grant_t valid,
                                      input logic [IDXW-1:0] ptr,
                                      input int nreq);
      grant_t     gnt;
      logic       found;
      logic [3:0] idx;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_NREQ; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= 4'(nreq)) idx = idx - 4'(nreq);
         if ((k < nreq) && !found && valid[idx[IDXW-1:0]]) begin
            gnt[idx[IDXW-1:0]] = 1'b1;
            found              = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant with a sticky lock owner.
//            This block holds the round-robin pointer and the lock-owner
//            state. Every grant is treated as an accept, because a grant is
//            only given to a requester that is valid.
// Ports    : clk      - clock
//            rst_n    - asynchronous active-low reset
//            valid_i  - per-requester request
//            lock_i   - per-requester lock request, sampled on accept
//            grant_o  - one-hot grant, zero when nothing is valid
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import rom_arb_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] valid_i,
   input  logic [NREQ-1:0] lock_i,
   output logic [NREQ-1:0] grant_o
);

   grant_t          valid_ext;
   grant_t          lock_ext;
   grant_t          lock_gnt;
   grant_t          grant_d;
   logic [IDXW-1:0] grant_idx;
   logic            lock_hit;
   logic            any_grant;

   logic [IDXW-1:0] ptr_q;
   logic [IDXW-1:0] owner_q;
   logic            owner_vld_q;

   always_comb begin
      valid_ext             = '0;
      valid_ext[NREQ-1:0]   = valid_i;
      lock_ext              = '0;
      lock_ext[NREQ-1:0]    = lock_i;
      lock_hit              = owner_vld_q && valid_ext[owner_q];
      lock_gnt              = '0;
      lock_gnt[owner_q]     = 1'b1;
      grant_d               = lock_hit ? lock_gnt : rr_pick(valid_ext, ptr_q, NREQ);
      grant_idx             = onehot_to_idx(grant_d);
      any_grant             = |grant_d;
   end

   assign grant_o = grant_d[NREQ-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
      end else if (any_grant) begin
         ptr_q       <= (grant_idx == IDXW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
         owner_q     <= grant_idx;
         owner_vld_q <= lock_ext[grant_idx];
      end else begin
         // No grant means nobody is valid, and that includes the owner.
         owner_vld_q <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rom_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_read_arbiter
// Purpose  : Shares one synchronous single-port ROM read port between NREQ
//            requesters. Arbitration is round-robin with an optional lock.
//            Each issued read is tagged, and the ROM word is returned to the
//            requester that issued it.
// Config   : `define ROM_ARB_RSP_REG_EN adds an output register on
//            rsp_valid/rsp_data. This makes the latency 2 cycles instead of 1.
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            req_valid    - per-requester read request
//            req_addr     - packed addresses, requester i at [i*ADDRW +: ADDRW]
//            req_lock     - keep the grant while the requester stays valid
//            req_ready    - one-hot accept
//            rsp_valid    - one-hot response strobe
//            rsp_data     - ROM word, broadcast to all requesters
//            rom_addr     - to ROM address input
//            rom_data     - from ROM data output (1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module rom_read_arbiter
   import rom_arb_pkg::*;
#(
   parameter  int NREQ  = 2,
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 256,
   localparam int ADDRW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*ADDRW-1:0] req_addr,
   input  logic [NREQ-1:0]       req_lock,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [ADDRW-1:0]      rom_addr,
   input  logic [WIDTH-1:0]      rom_data
);

   logic [NREQ-1:0]  arb_grant;
   logic [NREQ-1:0]  grant;
   logic             any_grant;
   logic [ADDRW-1:0] sel_addr;
   logic [ADDRW-1:0] addr_q;
   logic [NREQ-1:0]  tag_q;

   rr_arbiter #(
      .NREQ    (NREQ)
   ) u_rr_arbiter (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (req_valid),
      .lock_i  (req_lock),
      .grant_o (arb_grant)
   );

   // While reset is held, the grant is masked. This keeps req_ready and
   // rom_addr at their reset values even if requesters are already valid.
   assign grant     = arb_grant & {NREQ{rst_n}};
   assign any_grant = |grant;
   assign req_ready = grant;

   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) sel_addr = req_addr[i*ADDRW +: ADDRW];
      end
   end

   // When idle, the last issued address is held so the ROM input does not toggle.
   assign rom_addr = any_grant ? sel_addr : addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         tag_q  <= '0;
      end else begin
         tag_q <= grant;
         if (any_grant) addr_q <= sel_addr;
      end
   end

`ifdef ROM_ARB_RSP_REG_EN
   logic [NREQ-1:0]  rsp_valid_q;
   logic [WIDTH-1:0] rsp_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= tag_q;
         if (|tag_q) rsp_data_q <= rom_data;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
`else
   // The ROM word passes through while a tag is in flight. Otherwise the
   // output is zero, so rsp_data reads 0 out of reset.
   assign rsp_valid = tag_q;
   assign rsp_data  = (|tag_q) ? rom_data : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_read_arbiter
// Purpose  : Scoreboard bench for rom_read_arbiter with NREQ=2 and an 8-bit
//            ROM holding mem[k] = k ^ 8'hA5. A reference model predicts each
//            grant and the address it issues. A monitor then matches every
//            response against the predicted requester, data and arrival cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_read_arbiter;

   localparam int NREQ  = 2;
   localparam int WIDTH = 8;
   localparam int DEPTH = 256;
   localparam int ADDRW = 8;
`ifdef ROM_ARB_RSP_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic                  clk       = 1'b0;
   logic                  rst_n     = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*ADDRW-1:0] req_addr  = '0;
   logic [NREQ-1:0]       req_lock  = '0;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic [ADDRW-1:0]      rom_addr;
   logic [WIDTH-1:0]      rom_data  = '0;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   rom_read_arbiter #(
      .NREQ      (NREQ),
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_lock  (req_lock),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_word(input logic [7:0] a);
      return a ^ 8'hA5;
   endfunction

   // Behavioural ROM with a registered output.
   always @(posedge clk) rom_data <= rom_word(rom_addr);
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cycle, act, exp);
      end
   endtask

   // ---------------- reference model + scoreboard -------------------------
   typedef struct {
      int         due;
      int         idx;
      logic [7:0] data;
   } exp_t;

   exp_t       q[$];
   int         m_last = NREQ - 1;  // last served requester
   int         m_lock = -1;        // locked requester, -1 if none
   logic [7:0] m_addr = '0;        // last issued address
   int         m_g;
   int         m_c;
   logic [7:0] m_a;
   exp_t       m_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_last = NREQ - 1;
         m_lock = -1;
         m_addr = '0;
         q.delete();
      end else begin
         m_g = -1;
         if (m_lock >= 0 && req_valid[m_lock]) begin
            m_g = m_lock;
         end else begin
            for (int k = 1; k <= NREQ; k++) begin
               m_c = (m_last + k) % NREQ;
               if (m_g < 0 && req_valid[m_c]) m_g = m_c;
            end
         end
         check("req_ready", 32'(req_ready), (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
         if (m_g >= 0) begin
            m_a = req_addr[m_g*ADDRW +: ADDRW];
            check("rom_addr_grant", 32'(rom_addr), 32'(m_a));
            m_e.due  = cycle + LAT;
            m_e.idx  = m_g;
            m_e.data = rom_word(m_a);
            q.push_back(m_e);
            m_last = m_g;
            m_lock = req_lock[m_g] ? m_g : -1;
            m_addr = m_a;
         end else begin
            m_lock = -1;
            check("rom_addr_idle", 32'(rom_addr), 32'(m_addr));
         end
      end
   end

   exp_t r_e;
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
      end else if (q.size() > 0 && q[0].due == cycle) begin
         r_e = q.pop_front();
         check("rsp_valid", 32'(rsp_valid), 32'd1 << r_e.idx);
         check("rsp_data", 32'(rsp_data), 32'(r_e.data));
      end else begin
         check("rsp_valid_quiet", 32'(rsp_valid), 32'd0);
      end
   end

   // ---------------- stimulus ---------------------------------------------
   task automatic step(input logic [1:0] v, input logic [7:0] a0,
                       input logic [7:0] a1, input logic [1:0] l);
      req_valid = v;
      req_addr  = {a1, a0};
      req_lock  = l;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data", 32'(rsp_data), 32'd0);
      check("reset_rom_addr", 32'(rom_addr), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // single read by requester 0, address 3 -> 8'hA6
      step(2'b01, 8'd3, 8'd0, 2'b00);
      step(2'b00, 8'd0, 8'd0, 2'b00);
      step(2'b00, 8'd0, 8'd0, 2'b00);

      // both valid continuously: alternating grants, no gaps
      repeat (8) step(2'b11, 8'd10, 8'd20, 2'b00);
      step(2'b00, 8'd0, 8'd0, 2'b00);

      // align pointer to 1 with a read from 0, then requester 1 locks for 4
      step(2'b01, 8'd1, 8'd0, 2'b00);
      repeat (4) step(2'b11, 8'd30, 8'd40, 2'b10);
      step(2'b01, 8'd31, 8'd0, 2'b00);
      step(2'b00, 8'd0, 8'd0, 2'b00);

      // idle after a read of address 7
      step(2'b10, 8'd0, 8'd7, 2'b00);
      repeat (4) step(2'b00, 8'd55, 8'd66, 2'b00);

      // reset one cycle after an accept drops the in-flight response
      step(2'b10, 8'd0, 8'd9, 2'b00);
      rst_n     = 1'b0;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) step(2'b11, 8'd5, 8'd6, 2'b00);
      step(2'b00, 8'd0, 8'd0, 2'b00);

      // randomized traffic with occasional locks
      for (int n = 0; n < 400; n++) begin
         step(2'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
      end

      repeat (4) step(2'b00, 8'd0, 8'd0, 2'b00);
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
